// File: rtl/cell_vector_streamer.sv
// Vector-to-cellstruct serialiser feeding the ComputationCell chain: whole-vector FIFO,
// element-per-cycle framing and fixed idle gaps. Optional CELL_VECTOR_STREAMER_COUNT_EN adds vectorCount.
package cell_package;
  localparam int BITWIDTH = 8;
  localparam int WINDEX_W = 8;

  typedef struct packed {
    logic [BITWIDTH-1:0] data;
    logic                isValid;
    logic                isFirst;
    logic                isLast;
    logic [WINDEX_W-1:0] wIndex;
    logic                isResult;
  } cellstruct;
endpackage

module cell_vector_streamer
  import cell_package::*;
#(
  parameter int bitwidth        = 8,
  parameter int inputVectorSize = 3,
  parameter int gapCycles       = 2,
  parameter int bufferDepth     = 2
) (
  input  logic                                clock,
  input  logic                                resetN,
  input  logic [bitwidth*inputVectorSize-1:0] vecIn,
  input  logic                                vecValid,
  output logic                                vecReady,
  output cellstruct                           streamOut,
  output logic                                busy
`ifdef CELL_VECTOR_STREAMER_COUNT_EN
  ,
  output logic [15:0]                         vectorCount
`endif
);

  // state    | meaning
  // S_IDLE   | nothing in flight; pop the FIFO head as soon as one is buffered
  // S_STREAM | driving element r_idx of r_vec onto the stream this cycle
  // S_GAP    | inter-vector idle cycles, r_gap_cnt counts down to the exit
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

  localparam int VEC_W = bitwidth * inputVectorSize;
  localparam int PTR_W = (bufferDepth < 2) ? 1 : $clog2(bufferDepth);
  localparam int CNT_W = $clog2(bufferDepth + 1);
  localparam int IDX_W = (inputVectorSize < 2) ? 1 : $clog2(inputVectorSize);
  localparam int GAP_W = (gapCycles < 2) ? 1 : $clog2(gapCycles + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(inputVectorSize - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(gapCycles);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(bufferDepth - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(bufferDepth);

  logic [VEC_W-1:0] r_mem [bufferDepth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_vec;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  cellstruct        r_out;
  cellstruct        w_out_nxt;

  logic                w_push;
  logic                w_pop;
  logic                w_done;
  logic [bitwidth-1:0] w_elem;

  // Readiness comes only from the registered count, so a full FIFO never passes a vector through.
  assign vecReady  = (r_count < CNT_FULL);
  assign w_push    = vecValid && vecReady;
  assign w_elem    = r_vec[int'(r_idx)*bitwidth +: bitwidth];
  assign streamOut = r_out;
  assign busy      = (r_count != '0) || (r_state != S_IDLE) || r_out.isValid;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= vecIn;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_out_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_out_nxt.isValid = 1'b1;
        w_out_nxt.data    = w_elem;
        w_out_nxt.wIndex  = WINDEX_W'(r_idx);
        w_out_nxt.isFirst = (r_idx == '0);
        w_out_nxt.isLast  = (r_idx == IDX_LAST);
        if (r_idx == IDX_LAST) begin
          if (gapCycles == 0) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LOAD;
          end
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_GAP: begin
        // One GAP cycle per loaded count; the exit decision is taken on the final one.
        if (r_gap_cnt <= GAP_W'(1)) w_done = 1'b1;
        else                        w_gap_nxt = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_done) begin
      if (r_count != '0) begin
        w_pop       = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = S_STREAM;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_vec     <= '0;
      r_out     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_out     <= w_out_nxt;
      if (w_pop) r_vec <= r_mem[r_rd_ptr];
    end
  end

`ifdef CELL_VECTOR_STREAMER_COUNT_EN
  logic [15:0] r_vec_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)           r_vec_count <= '0;
    else if (r_out.isLast) r_vec_count <= r_vec_count + 16'd1;
  end

  assign vectorCount = r_vec_count;
`endif

endmodule
